// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory port between the instruction fetch unit (IFU,
// read-only) and the load/store unit (LSU, read/write). One transaction is in
// flight at a time: IDLE grants a requester round-robin, BUSY holds mem_ce for
// MEM_LAT cycles and samples read data on the last one, RESP presents the
// registered result to the owner until it is consumed.
//
// Parameters:
//   MEM_LAT        cycles mem_ce is held per access (1..15)
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   ifu_req_*      IFU read request handshake and address
//   ifu_resp_*     IFU response handshake, ifu_rdata holds the last read data
//   lsu_req_*      LSU request handshake, address, write flag, data and mask
//   lsu_resp_*     LSU response handshake, lsu_rdata is 0 after a write
//   mem_*          memory port; mem_rdata is combinational from mem_addr
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_rdata,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_addr,
    input  logic        lsu_we,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_rdata,

    output logic [63:0] mem_addr,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    owner_t      owner_q;
    owner_t      last_grant_q;
    owner_t      grant;

    logic [3:0]  cnt_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic        we_q;
    logic [63:0] ifu_rdata_q;
    logic [63:0] lsu_rdata_q;

    logic        accept;
    logic        last_beat;
    logic        resp_done;

    // Round-robin pick. With no requester valid the result is the port the
    // tie rule would choose, which is the only one allowed to show ready.
    always_comb begin
        grant = (last_grant_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
        if (ifu_req_valid && !lsu_req_valid) begin
            grant = OWN_IFU;
        end else if (lsu_req_valid && !ifu_req_valid) begin
            grant = OWN_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are masked while rst is high so an access interrupted by reset
    // cannot commit a write on the reset edge itself.
    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_ce         = 1'b0;
        mem_we         = 1'b0;
        mem_wmask      = '0;
        accept         = 1'b0;
        last_beat      = 1'b0;
        resp_done      = 1'b0;

        case (state)
            IDLE: begin
                if (!rst) begin
                    ifu_req_ready = (grant == OWN_IFU);
                    lsu_req_ready = (grant == OWN_LSU);
                end
                accept = (ifu_req_ready && ifu_req_valid) ||
                         (lsu_req_ready && lsu_req_valid);
                if (accept) begin
                    state_nxt = BUSY;
                end
            end

            BUSY: begin
                mem_ce    = !rst;
                last_beat = (cnt_q == 4'd0);
                if (last_beat) begin
                    // Write strobes only on the final beat: exactly one commit.
                    mem_we    = we_q && !rst;
                    mem_wmask = (we_q && !rst) ? wmask_q : '0;
                    state_nxt = RESP;
                end
            end

            RESP: begin
                if (!rst) begin
                    ifu_resp_valid = (owner_q == OWN_IFU);
                    lsu_resp_valid = (owner_q == OWN_LSU);
                end
                resp_done = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;
                if (resp_done) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            we_q         <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            if (accept) begin
                owner_q <= grant;
                cnt_q   <= CNT_INIT;
                if (grant == OWN_IFU) begin
                    addr_q  <= ifu_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end else begin
                    addr_q  <= lsu_addr;
                    we_q    <= lsu_we;
                    wdata_q <= lsu_wdata;
                    wmask_q <= lsu_wmask;
                end
            end

            if ((state == BUSY) && !last_beat) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (last_beat) begin
                if (owner_q == OWN_IFU) begin
                    ifu_rdata_q <= we_q ? '0 : mem_rdata;
                end else begin
                    lsu_rdata_q <= we_q ? '0 : mem_rdata;
                end
            end

            if (resp_done) begin
                last_grant_q <= owner_q;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed and randomized bench for mem_arbiter (MEM_LAT = 3). A small word
// memory answers the memory port; a separate transaction-level reference
// memory and a round-robin grant model produce every expected value.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT = 3;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PRE0 = 64'h0000_0013_0000_0093;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_ready;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ce, mem_we;
    logic [7:0]  mem_wmask;

    int tests = 0;
    int fails = 0;

    logic [63:0] dmem [64];
    logic [63:0] ref_mem [64];
    bit          mem_init = 1'b0;
    int          wr_count = 0;
    bit          last_lsu = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] wm);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Memory wrapper model: combinational read, byte-masked write at the edge.
    assign mem_rdata = mem_ce ? dmem[mem_addr[8:3]] : 64'h0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= (i == 0) ? PRE0 : 64'h0;
            mem_init <= 1'b1;
        end else if (mem_ce && mem_we) begin
            dmem[mem_addr[8:3]] <= merge(dmem[mem_addr[8:3]], mem_wdata, mem_wmask);
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from the IDLE cycle the caller has just set up
    // (called at a negedge). The winner comes from the round-robin model.
    task automatic run_txn(input int stall, input bit keep, output bit won_lsu);
        bit          exp_lsu, we, got;
        logic [63:0] a, wd, exp_data, other_before;
        logic [7:0]  wm;
        int          n, ce_n;
        exp_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);
        won_lsu = exp_lsu;
        a  = exp_lsu ? lsu_addr : ifu_addr;
        we = exp_lsu ? lsu_we : 1'b0;
        wd = lsu_wdata;
        wm = lsu_wmask;
        #1;
        chk("grant_ifu_ready", ifu_req_ready, !exp_lsu);
        chk("grant_lsu_ready", lsu_req_ready, exp_lsu);
        chk("idle_ce", mem_ce, 0);
        other_before = exp_lsu ? ifu_rdata : lsu_rdata;
        exp_data = we ? 64'h0 : ref_mem[a[8:3]];
        if (we) ref_mem[a[8:3]] = merge(ref_mem[a[8:3]], wd, wm);
        @(negedge clk);
        if (!keep) begin
            if (exp_lsu) lsu_req_valid = 1'b0;
            else         ifu_req_valid = 1'b0;
        end
        ce_n = 0;
        got  = 1'b0;
        for (n = 1; n <= 40; n++) begin
            #1;
            if (ifu_resp_valid || lsu_resp_valid) begin
                got = 1'b1;
                break;
            end
            if (mem_ce) begin
                ce_n++;
                chk("busy_addr", mem_addr, a);
                chk("busy_we", mem_we, we && (ce_n == LAT));
                chk("busy_wmask", mem_wmask, (we && (ce_n == LAT)) ? wm : 8'h0);
                if (we) chk("busy_wdata", mem_wdata, wd);
            end
            chk("busy_ready", {ifu_req_ready, lsu_req_ready}, 0);
            @(negedge clk);
        end
        chk("resp_seen", got, 1);
        chk("ce_cycles", ce_n, LAT);
        chk("latency", n, LAT + 1);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(negedge clk);
                #1;
            end
            chk("resp_ifu_valid", ifu_resp_valid, !exp_lsu);
            chk("resp_lsu_valid", lsu_resp_valid, exp_lsu);
            chk("resp_rdata", exp_lsu ? lsu_rdata : ifu_rdata, exp_data);
            chk("resp_other_rdata", exp_lsu ? ifu_rdata : lsu_rdata, other_before);
            chk("resp_ready", {ifu_req_ready, lsu_req_ready}, 0);
            chk("resp_mem", {mem_ce, mem_we, mem_wmask}, 0);
        end
        if (exp_lsu) lsu_resp_ready = 1'b1;
        else         ifu_resp_ready = 1'b1;
        @(posedge clk);
        last_lsu = exp_lsu;
        @(negedge clk);
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        int          wc;
        logic [63:0] keep5;

        for (int i = 0; i < 64; i++) ref_mem[i] = (i == 0) ? PRE0 : 64'h0;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_we = 0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_resp_ready = 0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_mem_ctl", {mem_ce, mem_we, mem_wmask}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_nobody_ifu", ifu_req_ready, 0);
        chk("idle_nobody_lsu", lsu_req_ready, 1);

        // IFU-only read of the preloaded word.
        @(negedge clk);
        ifu_req_valid = 1; ifu_addr = BASE;
        run_txn(0, 0, w);
        chk("ifu_read_data", ifu_rdata, 64'h0000_0013_0000_0093);
        chk("ifu_read_lsu_quiet", lsu_resp_valid, 0);

        // LSU write then read back through the byte mask.
        wc = wr_count;
        lsu_req_valid = 1; lsu_addr = BASE + 64'h100; lsu_we = 1;
        lsu_wdata = 64'h1122_3344_5566_7788; lsu_wmask = 8'h0F;
        run_txn(0, 0, w);
        chk("lsu_write_rdata", lsu_rdata, 0);
        chk("lsu_write_count", wr_count, wc + 1);
        lsu_req_valid = 1; lsu_we = 0;
        run_txn(0, 0, w);
        chk("lsu_readback", lsu_rdata, 64'h0000_0000_5566_7788);
        chk("lsu_read_no_write", wr_count, wc + 1);
        lsu_req_valid = 0;
        #1;
        chk("idle_after_lsu_ifu", ifu_req_ready, 1);
        chk("idle_after_lsu_lsu", lsu_req_ready, 0);

        // Reset in the second BUSY cycle of a write.
        @(negedge clk);
        wc = wr_count;
        keep5 = dmem[5];
        lsu_req_valid = 1; lsu_addr = BASE + 64'h28; lsu_we = 1;
        lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D; lsu_wmask = 8'hFF;
        @(negedge clk);
        lsu_req_valid = 0;
        #1;
        chk("rstbusy_ce1", mem_ce, 1);
        chk("rstbusy_wmask1", mem_wmask, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstbusy_wmask2", mem_wmask, 0);
        @(negedge clk);
        #1;
        chk("rstbusy_ce_drop", mem_ce, 0);
        chk("rstbusy_wmask3", mem_wmask, 0);
        rst = 1'b0;
        last_lsu = 1'b0;
        @(negedge clk);
        #1;
        chk("rstbusy_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rstbusy_idle_lsu_ready", lsu_req_ready, 1);
        chk("rstbusy_idle_ifu_ready", ifu_req_ready, 0);
        chk("rstbusy_no_write", wr_count, wc);
        chk("rstbusy_mem_kept", dmem[5], keep5);
        chk("rstbusy_lsu_rdata", lsu_rdata, 0);

        // Tie after reset: both held valid, grant alternates LSU, IFU, LSU, IFU.
        @(negedge clk);
        ifu_req_valid = 1; ifu_addr = BASE + 64'h8;
        lsu_req_valid = 1; lsu_addr = BASE + 64'h100; lsu_we = 0;
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 1, w);
            chk("tie_order", w, (k % 2) == 0);
        end

        // Backpressure on LSU with IFU waiting; IFU served right after release.
        run_txn(5, 0, w);
        chk("bp_lsu_first", w, 1);
        run_txn(0, 0, w);
        chk("bp_ifu_next", w, 0);

        // IFU request withdrawn during an LSU transaction: nothing happens.
        lsu_req_valid = 1; lsu_we = 0;
        run_txn(0, 0, w);
        ifu_req_valid = 1;
        run_txn(0, 0, w);
        lsu_req_valid = 1;
        @(negedge clk);
        lsu_req_valid = 0;
        ifu_req_valid = 1;
        #1;
        chk("withdraw_busy_ready", ifu_req_ready, 0);
        @(negedge clk);
        ifu_req_valid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (lsu_resp_valid) lsu_resp_ready = 1;
        end
        last_lsu = 1'b1;
        lsu_resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("withdraw_idle_ce", mem_ce, 0);
            chk("withdraw_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        end

        // Randomized mix checked against the reference memory and grant model.
        for (int k = 0; k < 40; k++) begin
            int pick;
            pick = $urandom_range(1, 3);
            ifu_req_valid = pick[0];
            lsu_req_valid = pick[1];
            ifu_addr  = BASE + {55'h0, 6'($urandom_range(0, 15)), 3'b000};
            lsu_addr  = BASE + {55'h0, 6'($urandom_range(0, 15)), 3'b000};
            lsu_we    = 1'($urandom_range(0, 1));
            lsu_wdata = {$urandom, $urandom};
            lsu_wmask = 8'($urandom);
            run_txn($urandom_range(0, 2), 0, w);
            ifu_req_valid = 0;
            lsu_req_valid = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
